// File: rtl/ho_pkg.sv
// rtl/ho_pkg.sv - shared state encoding and target codes for the handover decision block
package ho_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_GRANT   = 2'd3
  } ho_state_t;

  localparam logic [1:0] TGT_BS1  = 2'd0;
  localparam logic [1:0] TGT_BS2  = 2'd1;
  localparam logic [1:0] TGT_BS3  = 2'd2;
  localparam logic [1:0] TGT_NONE = 2'd3;

  localparam int SQ_THRESH = 50;

endpackage

// File: rtl/sq_filter.sv
// rtl/sq_filter.sv - one-channel signal-quality filter: first-sample load, then pairwise averaging
//   clk, reset : rising-edge clock, synchronous active-high reset
//   i_valid    : strobe qualifying i_raw
//   i_raw      : raw quality sample
//   o_sq       : filtered quality, updated the cycle after i_valid
module sq_filter #(
  parameter int SQ_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  input  logic [SQ_W-1:0] i_raw,
  output logic [SQ_W-1:0] o_sq
);

  logic            r_loaded;
  logic [SQ_W-1:0] r_sq;
  logic [SQ_W:0]   w_sum;

  // One extra bit so the sum of two full-scale samples cannot wrap before halving.
  assign w_sum = {1'b0, r_sq} + {1'b0, i_raw};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_loaded <= 1'b0;
      r_sq     <= '0;
    end else if (i_valid) begin
      r_loaded <= 1'b1;
      r_sq     <= r_loaded ? w_sum[SQ_W:1] : i_raw;
    end
  end

  assign o_sq = r_sq;

endmodule

// File: rtl/handover_decision.sv
// rtl/handover_decision.sv - filters BS quality reports and decides handover targets for requesting BSs
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   meas_valid           : strobe qualifying meas_sq1..3
//   meas_sq1..3          : raw quality of BS1..BS3
//   BS_DM_request[2:0]   : level-held better-BS request, bit n-1 from BSn
//   DM_BS1_sq..DM_BS3_sq : filtered quality per BS
//   DM_BS_target         : decided target code (3 = none)
//   DM_target_valid      : DM_BS_target holds a decision for the granted requester
//   DM_grant             : one-hot requester currently being answered
//   ho_count             : completed handovers, wrapping
module handover_decision
  import ho_pkg::*;
#(
  parameter int SQ_W = 8,
  parameter int HYST = 8,
  parameter int TTT  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            meas_valid,
  input  logic [SQ_W-1:0] meas_sq1,
  input  logic [SQ_W-1:0] meas_sq2,
  input  logic [SQ_W-1:0] meas_sq3,
  input  logic [2:0]      BS_DM_request,
  output logic [SQ_W-1:0] DM_BS1_sq,
  output logic [SQ_W-1:0] DM_BS2_sq,
  output logic [SQ_W-1:0] DM_BS3_sq,
  output logic [1:0]      DM_BS_target,
  output logic            DM_target_valid,
  output logic [2:0]      DM_grant,
  output logic [7:0]      ho_count
);

  localparam int               CNT_W  = (TTT > 1) ? $clog2(TTT + 1) : 1;
  localparam logic [CNT_W-1:0] TTT_C  = CNT_W'(TTT);
  localparam logic [SQ_W:0]    HYST_C = (SQ_W + 1)'(HYST);

  ho_state_t        r_state, w_state_nxt;
  logic [1:0]       r_req, w_req_nxt;
  logic [2:0]       r_grant, w_grant_nxt;
  logic [1:0]       r_cand, w_cand_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [1:0]       r_target, w_target_nxt;
  logic             r_tvalid, w_tvalid_nxt;
  logic [7:0]       r_ho_count, w_ho_count_nxt;
  logic             r_mv_d;

  logic [SQ_W-1:0]  w_sq1, w_sq2, w_sq3;
  logic [SQ_W-1:0]  w_best_sq, w_req_sq;
  logic [1:0]       w_best;
  logic             w_margin_ok, w_handover, w_req_held;
  logic             w_enter_grant;
  logic [1:0]       w_result;

  sq_filter #(.SQ_W(SQ_W)) u_filt1 (
    .clk(clk), .reset(reset), .i_valid(meas_valid), .i_raw(meas_sq1), .o_sq(w_sq1)
  );
  sq_filter #(.SQ_W(SQ_W)) u_filt2 (
    .clk(clk), .reset(reset), .i_valid(meas_valid), .i_raw(meas_sq2), .o_sq(w_sq2)
  );
  sq_filter #(.SQ_W(SQ_W)) u_filt3 (
    .clk(clk), .reset(reset), .i_valid(meas_valid), .i_raw(meas_sq3), .o_sq(w_sq3)
  );

  // Strict '>' keeps ties on the lower-index BS.
  always_comb begin
    w_best    = TGT_BS1;
    w_best_sq = w_sq1;
    if (w_sq2 > w_best_sq) begin
      w_best    = TGT_BS2;
      w_best_sq = w_sq2;
    end
    if (w_sq3 > w_best_sq) begin
      w_best    = TGT_BS3;
      w_best_sq = w_sq3;
    end
  end

  always_comb begin
    case (r_req)
      TGT_BS1: w_req_sq = w_sq1;
      TGT_BS2: w_req_sq = w_sq2;
      default: w_req_sq = w_sq3;
    endcase
  end

  assign w_margin_ok = {1'b0, w_best_sq} > ({1'b0, w_req_sq} + HYST_C);
  assign w_handover  = (w_best != r_req) && w_margin_ok;
  assign w_req_held  = |(BS_DM_request & r_grant);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_grant_nxt    = r_grant;
    w_cand_nxt     = r_cand;
    w_cnt_nxt      = r_cnt;
    w_target_nxt   = r_target;
    w_tvalid_nxt   = r_tvalid;
    w_ho_count_nxt = r_ho_count;
    w_enter_grant  = 1'b0;
    w_result       = r_req;

    case (r_state)
      ST_IDLE: begin
        if (BS_DM_request[0]) begin
          w_req_nxt   = TGT_BS1;
          w_grant_nxt = 3'b001;
          w_state_nxt = ST_SELECT;
        end else if (BS_DM_request[1]) begin
          w_req_nxt   = TGT_BS2;
          w_grant_nxt = 3'b010;
          w_state_nxt = ST_SELECT;
        end else if (BS_DM_request[2]) begin
          w_req_nxt   = TGT_BS3;
          w_grant_nxt = 3'b100;
          w_state_nxt = ST_SELECT;
        end
      end

      // Filter outputs here already include any sample strobed on the IDLE cycle.
      ST_SELECT: begin
        if (!w_req_held) begin
          w_grant_nxt = 3'b000;
          w_state_nxt = ST_IDLE;
        end else if (w_handover) begin
          w_cand_nxt  = w_best;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CONFIRM;
        end else begin
          w_enter_grant = 1'b1;
        end
      end

      // r_mv_d marks the first cycle the filters show a freshly strobed sample.
      ST_CONFIRM: begin
        if (!w_req_held) begin
          w_grant_nxt = 3'b000;
          w_state_nxt = ST_IDLE;
        end else if (r_mv_d) begin
          if (w_handover && (w_best == r_cand)) begin
            if (w_cnt_inc == TTT_C) begin
              w_enter_grant = 1'b1;
              w_result      = r_cand;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_enter_grant = 1'b1;
          end
        end
      end

      ST_GRANT: begin
        if (!w_req_held) begin
          w_state_nxt  = ST_IDLE;
          w_target_nxt = TGT_NONE;
          w_tvalid_nxt = 1'b0;
          w_grant_nxt  = 3'b000;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_enter_grant) begin
      w_state_nxt  = ST_GRANT;
      w_target_nxt = w_result;
      w_tvalid_nxt = 1'b1;
      if (w_result != r_req) begin
        w_ho_count_nxt = r_ho_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_req      <= TGT_BS1;
      r_grant    <= 3'b000;
      r_cand     <= TGT_BS1;
      r_cnt      <= '0;
      r_target   <= TGT_NONE;
      r_tvalid   <= 1'b0;
      r_ho_count <= 8'd0;
      r_mv_d     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_grant    <= w_grant_nxt;
      r_cand     <= w_cand_nxt;
      r_cnt      <= w_cnt_nxt;
      r_target   <= w_target_nxt;
      r_tvalid   <= w_tvalid_nxt;
      r_ho_count <= w_ho_count_nxt;
      r_mv_d     <= meas_valid;
    end
  end

  assign DM_BS1_sq       = w_sq1;
  assign DM_BS2_sq       = w_sq2;
  assign DM_BS3_sq       = w_sq3;
  assign DM_BS_target    = r_target;
  assign DM_target_valid = r_tvalid;
  assign DM_grant        = r_grant;
  assign ho_count        = r_ho_count;

endmodule
